pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the RV32 core, superseding the fixed 2-output load-use/jump stall logic. It arbitrates load-use stalls, taken-branch/jump redirects and multi-cycle EX operations (e.g. divider). It drives a PC hold plus a per-pipeline-register hold/flush vector. Sits beside the hazard-detection and forwarding logic. Its outputs feed the PC register and every inter-stage pipeline register.

Parameters:
NUM_STAGES, 5, pipeline depth; NR = NUM_STAGES-1 pipeline registers, index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB
LU_STALL_CYC, 1, load-use stall length in cycles (1..15)
BR_FLUSH_CYC, 2, number of youngest pipeline registers flushed on redirect (1..NR)
MC_STAGE, 2, stage index executing multi-cycle ops; registers 0..MC_STAGE-1 held, register MC_STAGE bubbled
MC_MAX, 32, multi-cycle timeout in cycles; counter width = $clog2(MC_MAX+1)

Ports:
clock  in  1  core clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
stall_lw  in  1  load-use hazard detected in ID this cycle
redirect  in  1  taken branch/jump resolved this cycle (PC loads target)
mc_start  in  1  multi-cycle op entering wait this cycle
mc_done  in  1  multi-cycle result valid this cycle
pc_hold  out  1  PC must not update
reg_hold  out  NR  per-register hold; bit i freezes register i
reg_flush  out  NR  per-register flush; bit i loads a bubble into register i
mc_timeout  out  1  one-cycle pulse when a multi-cycle wait is aborted at MC_MAX
hz_state  out  2  current FSM state (debug)

Behaviour:
- Outputs are combinational from the registered state and this-cycle inputs. While reset is high, all outputs are 0 and hz_state = RUN.
- The state, lu_cnt, mc_cnt and cool flag are registered and asynchronously cleared by reset.
- States: RUN=0, LU_STALL=1, MC_WAIT=2. Encoding 3 is unused and recovers to RUN.
- Input priority in every state is redirect > mc > stall_lw.
- RUN:
  - redirect=1: reg_flush[BR_FLUSH_CYC-1:0]=1, no holds, stay RUN. Any stall_lw or mc_start in the same cycle is dropped.
  - else mc_start=1: pc_hold=1, reg_hold[MC_STAGE-1:0]=1, reg_flush[MC_STAGE]=1, mc_cnt<=1, go MC_WAIT. If mc_done=1 in the same cycle, no hold and stay RUN.
  - else stall_lw=1 and cool=0: pc_hold=1, reg_hold[0]=1, reg_flush[1]=1. If LU_STALL_CYC=1, set cool<=1 and stay RUN; otherwise lu_cnt<=LU_STALL_CYC-1 and go LU_STALL.
  - else: all outputs 0, cool<=0.
- LU_STALL:
  - Drives the same holds/flush as the RUN stall cycle and decrements lu_cnt.
  - At lu_cnt==1: go RUN, cool<=1.
  - stall_lw is ignored while in this state.
  - redirect=1: abort the stall (flush only, no holds), lu_cnt<=0, go RUN.
- Cooldown: the single cycle with cool=1 masks stall_lw, so one hazard never re-stalls. This guarantees forward progress.
- MC_WAIT:
  - Each cycle drives pc_hold=1, reg_hold[MC_STAGE-1:0]=1, reg_flush[MC_STAGE]=1, and increments mc_cnt.
  - mc_done=1: all outputs 0 this cycle, go RUN.
  - mc_cnt==MC_MAX and mc_done=0: mc_timeout=1, release holds, go RUN.
  - redirect and stall_lw are ignored in this state. A redirect cannot originate while EX is occupied.
- Hold and flush are never both 1 on the same bit. The bench checks this as an invariant.
- Reset asserted mid-stall: the block is in RUN with all outputs 0 immediately, without waiting for a clock edge.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds three 32-bit outputs stall_lu_cycles, stall_mc_cycles and flush_events.
  - stall_lu_cycles and stall_mc_cycles count cycles with pc_hold=1 per cause.
  - flush_events counts redirect cycles.
  - All three are cleared by reset, saturate at all-ones, and are updated on clock.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package haz_pkg holds:
  - the state enum (RUN/LU_STALL/MC_WAIT)
  - stage index constants (IFID=0, IDEX=1, EXMEM=2, MEMWB=3)
  - the 2-bit state width
- One sub-module, hz_cycle_cnt: a loadable up/down counter with terminal-count flag. It is instantiated twice, for lu_cnt and mc_cnt.

Test Plan:
- Default params, stall_lw pulse 1 cycle → pc_hold=1, reg_hold=4'b0001, reg_flush=4'b0010 for 1 cycle. stall_lw held high 3 cycles → stall cycles 1 and 3 only; cooldown masks cycle 2.
- LU_STALL_CYC=3, stall_lw pulse → holds for exactly 3 cycles, then hz_state=0. Redirect in stall cycle 2 → reg_flush=4'b0011, no holds, back in RUN next cycle.
- redirect and stall_lw and mc_start together in RUN → only reg_flush=4'b0011; no hold; hz_state stays 0.
- mc_start, mc_done after 5 cycles → pc_hold, reg_hold=4'b0011, reg_flush=4'b0100 for 5 cycles, released in the mc_done cycle.
- MC_MAX=8, mc_start, mc_done never → mc_timeout pulses in the 8th wait cycle, holds drop, hz_state=0.
- Reset asserted mid-MC_WAIT between clock edges → all outputs 0 asynchronously. After release, stall_lw behaves as from power-up (no cooldown). With HAZ_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package haz_pkg;

  localparam int unsigned STATE_W = 2;

  // Pipeline register indices.
  localparam int unsigned IFID  = 0;
  localparam int unsigned IDEX  = 1;
  localparam int unsigned EXMEM = 2;
  localparam int unsigned MEMWB = 3;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_cnt.sv
// Loadable up/down cycle counter with a terminal-count flag at TC.
module hz_cycle_cnt #(
  parameter int unsigned W  = 4,
  parameter int unsigned TC = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Load has priority over counting; up and down are mutually exclusive in use.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  // Terminal count reached.
  assign tc = (cnt == W'(TC));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates redirects, multi-cycle EX waits and
// load-use stalls into a PC hold plus per-register hold/flush vectors.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
  import haz_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned BR_FLUSH_CYC = 2,
  parameter int unsigned MC_STAGE     = 2,
  parameter int unsigned MC_MAX       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall_lw,
  input  logic                  redirect,
  input  logic                  mc_start,
  input  logic                  mc_done,
  output logic                  pc_hold,
  output logic [NUM_STAGES-2:0] reg_hold,
  output logic [NUM_STAGES-2:0] reg_flush,
  output logic                  mc_timeout,
  output logic [STATE_W-1:0]    hz_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_lu_cycles,
  output logic [31:0]           stall_mc_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam int unsigned NR   = NUM_STAGES - 1;
  localparam int unsigned LU_W = 4;
  localparam int unsigned MC_W = $clog2(MC_MAX + 1);

  localparam logic [NR-1:0] BR_FLUSH_MASK = NR'((2 ** BR_FLUSH_CYC) - 1);
  localparam logic [NR-1:0] MC_HOLD_MASK  = NR'((2 ** MC_STAGE) - 1);
  localparam logic [NR-1:0] MC_FLUSH_MASK = NR'(2 ** MC_STAGE);
  localparam logic [NR-1:0] LU_HOLD_MASK  = NR'(2 ** IFID);
  localparam logic [NR-1:0] LU_FLUSH_MASK = NR'(2 ** IDEX);

  hz_state_e       state_q, state_d;
  logic            cool_q, cool_d;

  logic            lu_load, lu_dec, lu_tc;
  logic [LU_W-1:0] lu_load_val, lu_cnt;
  logic            mc_load, mc_inc, mc_tc;
  logic [MC_W-1:0] mc_load_val, mc_cnt;

  // Remaining load-use stall cycles.
  hz_cycle_cnt #(.W(LU_W), .TC(1)) u_lu_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (lu_load),
    .load_val (lu_load_val),
    .inc      (1'b0),
    .dec      (lu_dec),
    .cnt      (lu_cnt),
    .tc       (lu_tc)
  );

  // Elapsed multi-cycle wait cycles.
  hz_cycle_cnt #(.W(MC_W), .TC(MC_MAX)) u_mc_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (mc_load),
    .load_val (mc_load_val),
    .inc      (mc_inc),
    .dec      (1'b0),
    .cnt      (mc_cnt),
    .tc       (mc_tc)
  );

  // State and cooldown registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cool_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
    end
  end

  // Next state and hazard outputs; priority redirect > multi-cycle > load-use.
  always_comb begin
    state_d     = state_q;
    cool_d      = 1'b0;
    pc_hold     = 1'b0;
    reg_hold    = '0;
    reg_flush   = '0;
    mc_timeout  = 1'b0;
    lu_load     = 1'b0;
    lu_load_val = '0;
    lu_dec      = 1'b0;
    mc_load     = 1'b0;
    mc_load_val = '0;
    mc_inc      = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect) begin
          reg_flush = BR_FLUSH_MASK;
        end else if (mc_start) begin
          if (!mc_done) begin
            pc_hold     = 1'b1;
            reg_hold    = MC_HOLD_MASK;
            reg_flush   = MC_FLUSH_MASK;
            mc_load     = 1'b1;
            mc_load_val = MC_W'(1);
            state_d     = MC_WAIT;
          end
        end else if (stall_lw && !cool_q) begin
          pc_hold   = 1'b1;
          reg_hold  = LU_HOLD_MASK;
          reg_flush = LU_FLUSH_MASK;
          if (LU_STALL_CYC == 1) begin
            cool_d = 1'b1;
          end else begin
            lu_load     = 1'b1;
            lu_load_val = LU_W'(LU_STALL_CYC - 1);
            state_d     = LU_STALL;
          end
        end
      end

      LU_STALL: begin
        if (redirect) begin
          reg_flush = BR_FLUSH_MASK;
          lu_load   = 1'b1;
          state_d   = RUN;
        end else if (mc_start && !mc_done) begin
          pc_hold     = 1'b1;
          reg_hold    = MC_HOLD_MASK;
          reg_flush   = MC_FLUSH_MASK;
          lu_load     = 1'b1;
          mc_load     = 1'b1;
          mc_load_val = MC_W'(1);
          state_d     = MC_WAIT;
        end else if (lu_cnt == '0) begin
          // Corrupted counter: recover rather than stall forever.
          state_d = RUN;
        end else begin
          pc_hold   = 1'b1;
          reg_hold  = LU_HOLD_MASK;
          reg_flush = LU_FLUSH_MASK;
          lu_dec    = 1'b1;
          if (lu_tc) begin
            state_d = RUN;
            cool_d  = 1'b1;
          end
        end
      end

      MC_WAIT: begin
        if (mc_done) begin
          state_d = RUN;
        end else if (mc_tc) begin
          mc_timeout = 1'b1;
          state_d    = RUN;
        end else if (mc_cnt == '0) begin
          // Corrupted counter: recover rather than wait forever.
          state_d = RUN;
        end else begin
          pc_hold   = 1'b1;
          reg_hold  = MC_HOLD_MASK;
          reg_flush = MC_FLUSH_MASK;
          mc_inc    = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Outputs are quiet immediately while reset is asserted.
    if (reset) begin
      pc_hold    = 1'b0;
      reg_hold   = '0;
      reg_flush  = '0;
      mc_timeout = 1'b0;
    end
  end

  assign hz_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic lu_cause, mc_cause, redirect_act;

  // Attribute each held cycle to its cause; redirects act only in RUN/LU_STALL.
  assign mc_cause     = pc_hold && ((state_q == MC_WAIT) || (mc_start && !mc_done));
  assign lu_cause     = pc_hold && !mc_cause;
  assign redirect_act = redirect && !reset &&
                        ((state_q == RUN) || (state_q == LU_STALL));

  // Saturating performance counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_lu_cycles <= '0;
      stall_mc_cycles <= '0;
      flush_events    <= '0;
    end else begin
      if (lu_cause && (stall_lu_cycles != '1)) stall_lu_cycles <= stall_lu_cycles + 32'd1;
      if (mc_cause && (stall_mc_cycles != '1)) stall_mc_cycles <= stall_mc_cycles + 32'd1;
      if (redirect_act && (flush_events != '1)) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: table of per-cycle vectors on a default-parameter instance,
// plus hand sequences on an LU_STALL_CYC=3 / MC_MAX=8 instance.
module tb_pipe_hazard_ctrl;

  logic       clock, reset;
  logic       stall_lw, redirect, mc_start, mc_done;

  logic       ph0, to0, ph3, to3;
  logic [3:0] hold0, flush0, hold3, flush3;
  logic [1:0] st0, st3;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu0, mcc0, fe0, lu3, mcc3, fe3;
`endif

  pipe_hazard_ctrl u_dut (
    .clock      (clock),
    .reset      (reset),
    .stall_lw   (stall_lw),
    .redirect   (redirect),
    .mc_start   (mc_start),
    .mc_done    (mc_done),
    .pc_hold    (ph0),
    .reg_hold   (hold0),
    .reg_flush  (flush0),
    .mc_timeout (to0),
    .hz_state   (st0)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_lu_cycles (lu0),
    .stall_mc_cycles (mcc0),
    .flush_events    (fe0)
`endif
  );

  pipe_hazard_ctrl #(.LU_STALL_CYC(3), .MC_MAX(8)) u_dut3 (
    .clock      (clock),
    .reset      (reset),
    .stall_lw   (stall_lw),
    .redirect   (redirect),
    .mc_start   (mc_start),
    .mc_done    (mc_done),
    .pc_hold    (ph3),
    .reg_hold   (hold3),
    .reg_flush  (flush3),
    .mc_timeout (to3),
    .hz_state   (st3)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_lu_cycles (lu3),
    .stall_mc_cycles (mcc3),
    .flush_events    (fe3)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output words: {pc_hold, reg_hold[3:0], reg_flush[3:0], mc_timeout, hz_state[1:0]}
  localparam logic [11:0] E_IDLE = 12'b0_0000_0000_0_00;
  localparam logic [11:0] E_LU   = 12'b1_0001_0010_0_00;
  localparam logic [11:0] E_LUS  = 12'b1_0001_0010_0_01;
  localparam logic [11:0] E_BR   = 12'b0_0000_0011_0_00;
  localparam logic [11:0] E_BRL  = 12'b0_0000_0011_0_01;
  localparam logic [11:0] E_MC0  = 12'b1_0011_0100_0_00;
  localparam logic [11:0] E_MCW  = 12'b1_0011_0100_0_10;
  localparam logic [11:0] E_MCD  = 12'b0_0000_0000_0_10;
  localparam logic [11:0] E_TO   = 12'b0_0000_0000_1_10;

  typedef struct {
    logic [3:0]  in;   // {stall_lw, redirect, mc_start, mc_done}
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [18];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [11:0] got0();
    return {ph0, hold0, flush0, to0, st0};
  endfunction

  function automatic logic [11:0] got3();
    return {ph3, hold3, flush3, to3, st3};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ph=%b hold=%b flush=%b to=%b st=%0d, want ph=%b hold=%b flush=%b to=%b st=%0d",
               name, act[11], act[10:7], act[6:3], act[2], act[1:0],
               exp[11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
    end
    n_vec++;
    if ((act[10:7] & act[6:3]) != 4'b0000) begin
      n_bad++;
      $display("FAIL %s_overlap: hold=%b flush=%b share a bit", name, act[10:7], act[6:3]);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    @(negedge clock);
    {stall_lw, redirect, mc_start, mc_done} = in;
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clock);
    {stall_lw, redirect, mc_start, mc_done} = 4'b0000;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, E_IDLE};
    tbl[1]  = '{4'b1000, E_LU};    // single load-use stall
    tbl[2]  = '{4'b0000, E_IDLE};
    tbl[3]  = '{4'b1000, E_LU};    // stall_lw held 3 cycles
    tbl[4]  = '{4'b1000, E_IDLE};  // cooldown masks
    tbl[5]  = '{4'b1000, E_LU};
    tbl[6]  = '{4'b0000, E_IDLE};
    tbl[7]  = '{4'b1110, E_BR};    // redirect wins over mc and stall
    tbl[8]  = '{4'b1000, E_LU};
    tbl[9]  = '{4'b0000, E_IDLE};
    tbl[10] = '{4'b0011, E_IDLE};  // start and done together
    tbl[11] = '{4'b0010, E_MC0};
    tbl[12] = '{4'b0000, E_MCW};
    tbl[13] = '{4'b1100, E_MCW};   // redirect/stall ignored in MC_WAIT
    tbl[14] = '{4'b0000, E_MCW};
    tbl[15] = '{4'b0000, E_MCW};
    tbl[16] = '{4'b0001, E_MCD};   // released in the done cycle
    tbl[17] = '{4'b0000, E_IDLE};

    // Reset: outputs quiet even with redirect asserted.
    reset = 1'b1;
    {stall_lw, redirect, mc_start, mc_done} = 4'b0100;
    @(negedge clock);
    #1;
    chk("reset_dut", got0(), E_IDLE);
    chk("reset_dut3", got3(), E_IDLE);
    @(negedge clock);
    reset = 1'b0;
    redirect = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].in);
      chk($sformatf("vec%0d", i), got0(), tbl[i].exp);
    end
`ifdef HAZ_PERF_CNT_EN
    chk32("perf_lu", lu0, 32'd4);
    chk32("perf_mc", mcc0, 32'd5);
    chk32("perf_flush", fe0, 32'd1);
`endif

    // Three-cycle load-use stall.
    rst_pulse();
    drive(4'b1000); chk("lu3_c1", got3(), E_LU);
    drive(4'b0000); chk("lu3_c2", got3(), E_LUS);
    drive(4'b0000); chk("lu3_c3", got3(), E_LUS);
    drive(4'b0000); chk("lu3_end", got3(), E_IDLE);

    // Redirect aborts a stall in its second cycle.
    drive(4'b1000); chk("lu3_ab1", got3(), E_LU);
    drive(4'b0100); chk("lu3_abr", got3(), E_BRL);
    drive(4'b0000); chk("lu3_abend", got3(), E_IDLE);

    // Multi-cycle timeout at MC_MAX=8.
    drive(4'b0010); chk("to_start", got3(), E_MC0);
    for (int i = 1; i <= 7; i++) begin
      drive(4'b0000);
      chk($sformatf("to_wait%0d", i), got3(), E_MCW);
    end
    drive(4'b0000); chk("to_pulse", got3(), E_TO);
    drive(4'b0000); chk("to_after", got3(), E_IDLE);

    // Asynchronous reset in the middle of MC_WAIT.
    drive(4'b0010); chk("ar_start", got3(), E_MC0);
    drive(4'b0000); chk("ar_wait", got3(), E_MCW);
    #2 reset = 1'b1;
    #1;
    chk("ar_dut", got0(), E_IDLE);
    chk("ar_dut3", got3(), E_IDLE);
`ifdef HAZ_PERF_CNT_EN
    chk32("ar_perf_lu", lu0, 32'd0);
    chk32("ar_perf_mc", mcc0, 32'd0);
    chk32("ar_perf_flush", fe0, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    // Reset clears the cooldown: stall re-asserts right after a reset pulse.
    drive(4'b1000); chk("cool_pre", got0(), E_LU);
    @(posedge clock);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("cool_post", got0(), E_LU);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
